data_mem_cache: RTL and testbench
=================================

# data_mem_cache

Parametrised data-memory successor for the RV32I core: a direct-mapped, write-through read cache in front of an internal word-organised backing store with a configurable miss latency. Supports byte/halfword/word loads and stores with sign/zero extension selected by `sign_mask`, drives `clk_stall` to freeze the pipeline on read misses, and keeps the memory-mapped LED register. Sits in the MEM stage between the ALU address path and the write-back mux.

## Interface
- `LINES`, 16, number of cache lines (one 32-bit word per line, power of two, ≥2)
- `MEM_WORDS`, 1024, backing store depth in words (power of two, > `LINES`)
- `MISS_LATENCY`, 4, cycles `clk_stall` is held on a read miss (≥1)
- `LED_ADDR`, 32'h0000_2000, byte address whose word stores also update `led`

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset: synchronous, active-high
- `addr`  in  32  byte address
- `write_data`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `memwrite`  in  1  store request
- `memread`  in  1  load request
- `sign_mask`  in  4  [3]=sign-extend on load; [2:0]=size: 001 byte, 011 half, 111 word
- `read_data`  out  32  registered load result
- `led`  out  8  LED register
- `clk_stall`  out  1  high while a read miss is being serviced

## Operation
- Address decode: word index `W = addr[log2(MEM_WORDS)+1:2]` (upper bits ignored, wraps); line `L = W[log2(LINES)-1:0]`; tag = remaining bits of `W`. Byte offset `addr[1:0]`; half uses `addr[1]`; word ignores `addr[1:0]`.
- Per line: valid bit, tag, 32-bit data. Only valid bits are cleared by reset; data/tag and backing store are not.
- A request is accepted on a rising edge with `clk_stall=0` and `memread|memwrite`. Both high → write wins, read ignored. Requests while `clk_stall=1` are ignored.
- Store: merges size-selected lanes of `write_data` into the backing word at `W`. If `L` is valid with matching tag, the line is updated identically (write-through, no write-allocate). Undefined size codes → no state change. If `W` equals `LED_ADDR` word index: `led <= write_data[7:0]` (also stored). `read_data` unchanged.
- Load hit: `read_data` formatted from the line word. Load miss: latch `W`, offset, `sign_mask`; state MISS.
- Format: select byte at offset / half at `addr[1]` / whole word; sign-extend if `sign_mask[3]`, else zero-extend. Undefined size → 0.
- FSM: IDLE → MISS on load miss (counter loaded with `MISS_LATENCY-1`); MISS decrements each cycle; on the edge where counter = 0: fill line (valid=1, tag, backing word), write formatted `read_data` from latched fields, → IDLE. No other transitions.

## Timing
- Reset values: `read_data=0`, `led=0`, `clk_stall=0`, state IDLE, all valid bits 0.
- `clk_stall` is registered: rises the cycle after the accepting edge of a miss, high for exactly `MISS_LATENCY` cycles, falls the same edge `read_data` updates.
- Load hit latency: 1 edge; no stall.
- Load miss latency: `MISS_LATENCY+1` edges from acceptance to valid `read_data`.
- Store: completes at the accepting edge; never stalls; a load accepted on the next edge sees the new data (hit or miss).
- `rst` during MISS: abort, no line fill, `read_data=0`, `clk_stall=0` next cycle.
- Requester may change `addr`/`sign_mask` during stall; the latched values are used.

## Test plan
- Reset, store byte `addr=0x400`, `write_data=0xAAA`, mask 0001 → load mask 1001: `clk_stall` high 4 cycles, `read_data=0xFFFFFFAA`; repeat with mask 0001 → hit, no stall, `0x000000AA`.
- Store half `addr=0x100`, `write_data=0x2AAAA`, mask 0011 → load mask 1011 = `0xFFFFAAAA` (miss), mask 0011 = `0x0000AAAA` (hit); half at `addr=0x102` reads unchanged.
- Store word `0xAAAAAAAA` at `0x40`, load → `0xAAAAAAAA`; store byte `0x55` at `0x43` after line is valid → hit-load word = `0x55AAAAAA`, no stall.
- Conflict: load `0x40` then `0x80` (same line with `LINES=16`) → both miss; reload `0x40` misses again.
- Store `0x5A` to `LED_ADDR` → `led=0x5A` next cycle; simultaneous `memread=memwrite=1` performs store only, `read_data` unchanged.
- Assert `rst` in 2nd stall cycle → `clk_stall=0`, `read_data=0`; reload same address misses again (no fill).

Source files
------------

// File: rtl/data_mem_cache.sv
// Direct-mapped write-through read cache over a word-organised backing store.
// Read misses stall the pipeline for MISS_LATENCY cycles before the line is filled.
module data_mem_cache #(
  parameter int          LINES        = 16,
  parameter int          MEM_WORDS    = 1024,
  parameter int          MISS_LATENCY = 4,
  parameter logic [31:0] LED_ADDR     = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
);
  localparam int WA = $clog2(MEM_WORDS);
  localparam int LA = $clog2(LINES);
  localparam int TA = WA - LA;
  localparam int CW = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [WA-1:0] LED_WORD = LED_ADDR[WA+1:2];

  typedef enum logic {IDLE, MISS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stall_q;

  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     line_data [LINES];
  logic [TA-1:0]   line_tag [LINES];
  logic [LINES-1:0] line_vld;

  logic [WA-1:0]   miss_word_p1;
  logic [1:0]      miss_off_p1;
  logic [3:0]      miss_mask_p1;

  logic [WA-1:0]   word_idx;
  logic [LA-1:0]   line_idx;
  logic [TA-1:0]   tag;
  logic [LA-1:0]   miss_line;
  logic [TA-1:0]   miss_tag;
  logic            hit, size_ok, accept, store_ok, load_hit, miss_start, fill;
  logic [31:0]     store_word;
  logic            unused_addr_hi;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (size)
      3'b001:  r[8*off +: 8] = wd[7:0];
      3'b011:  r[16*off[1] +: 16] = wd[15:0];
      3'b111:  r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [3:0] mask,
                                           input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[8*off +: 8];
    h = word[16*off[1] +: 16];
    case (mask[2:0])
      3'b001:  r = mask[3] ? 32'(b) : {24'd0, b};
      3'b011:  r = mask[3] ? 32'(h) : {16'd0, h};
      3'b111:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Stage p0: decode and tag compare on the incoming request
  assign word_idx       = addr[WA+1:2];
  assign line_idx       = word_idx[LA-1:0];
  assign tag            = word_idx[WA-1:LA];
  assign unused_addr_hi = ^addr[31:WA+2];
  assign miss_line      = miss_word_p1[LA-1:0];
  assign miss_tag       = miss_word_p1[WA-1:LA];

  assign hit        = line_vld[line_idx] && (line_tag[line_idx] == tag);
  assign size_ok    = (sign_mask[2:0] == 3'b001) || (sign_mask[2:0] == 3'b011) ||
                      (sign_mask[2:0] == 3'b111);
  assign accept     = !rst && (state_q == IDLE) && (memread || memwrite);
  assign store_ok   = accept && memwrite && size_ok;
  assign load_hit   = accept && !memwrite && hit;
  assign miss_start = accept && !memwrite && !hit;
  assign fill       = !rst && (state_q == MISS) && (cnt_q == '0);
  assign store_word = merge_lanes(mem[word_idx], write_data, sign_mask[2:0], addr[1:0]);
  assign clk_stall  = stall_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (miss_start) begin
        state_d = MISS;
        cnt_d   = CW'(MISS_LATENCY - 1);
      end
      MISS: if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      line_vld  <= '0;
      read_data <= 32'd0;
      led       <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == MISS);
      if (fill) begin
        line_vld[miss_line] <= 1'b1;
        read_data <= fmt_load(mem[miss_word_p1], miss_mask_p1, miss_off_p1);
      end else if (load_hit) begin
        read_data <= fmt_load(line_data[line_idx], sign_mask, addr[1:0]);
      end
      if (store_ok && (word_idx == LED_WORD)) led <= write_data[7:0];
    end
  end

  // Stage p1: backing store, line storage and latched miss fields
  always_ff @(posedge clk) begin
    if (store_ok) begin
      mem[word_idx] <= store_word;
      if (hit) line_data[line_idx] <= store_word;
    end
    if (miss_start) begin
      miss_word_p1 <= word_idx;
      miss_off_p1  <= addr[1:0];
      miss_mask_p1 <= sign_mask;
    end
    if (fill) begin
      line_data[miss_line] <= mem[miss_word_p1];
      line_tag[miss_line]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_data_mem_cache.sv
// Randomised bench for data_mem_cache against a word-array / line-ownership model.
module tb_data_mem_cache;
  localparam int          LINES     = 16;
  localparam int          MEM_WORDS = 1024;
  localparam int          LAT       = 4;
  localparam logic [31:0] LED_ADDR  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, write_data, read_data;
  logic        memwrite, memread, clk_stall;
  logic [3:0]  sign_mask;
  logic [7:0]  led;

  data_mem_cache #(.LINES(LINES), .MEM_WORDS(MEM_WORDS), .MISS_LATENCY(LAT), .LED_ADDR(LED_ADDR)) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .memwrite(memwrite),
    .memread(memread), .sign_mask(sign_mask), .read_data(read_data), .led(led),
    .clk_stall(clk_stall)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_mem [MEM_WORDS];
  int          m_line [LINES];
  logic [31:0] m_rd;
  logic [7:0]  m_led;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit size_ok(input logic [3:0] m);
    return (m[2:0] == 3'd1) || (m[2:0] == 3'd3) || (m[2:0] == 3'd7);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [3:0] m,
                                           input logic [1:0] off);
    int     sh, width;
    longint v;
    case (m[2:0])
      3'd1: begin sh = 8 * off;    width = 8;  end
      3'd3: begin sh = 16 * off[1]; width = 16; end
      3'd7: begin sh = 0;          width = 32; end
      default: return 32'd0;
    endcase
    v = (longint'(word) >> sh) & ((longint'(1) << width) - 1);
    if (m[3] && v >= (longint'(1) << (width - 1))) v = v - (longint'(1) << width);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wd,
                                            input logic [3:0] m, input logic [1:0] off);
    logic [31:0] msk;
    int          sh;
    case (m[2:0])
      3'd1:    begin sh = 8 * off;     msk = 32'h0000_00FF << sh; end
      3'd3:    begin sh = 16 * off[1]; msk = 32'h0000_FFFF << sh; end
      default: begin sh = 0;           msk = 32'hFFFF_FFFF;       end
    endcase
    return (word & ~msk) | ((wd << sh) & msk);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_line[i] = -1;
    m_rd  = 32'd0;
    m_led = 8'd0;
  endtask

  task automatic op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] m);
    int         w, l;
    logic [1:0] off;
    w   = int'((a >> 2) % MEM_WORDS);
    l   = w % LINES;
    off = a[1:0];
    @(negedge clk);
    addr = a; write_data = wd; memwrite = wr; memread = rd; sign_mask = m;
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
    if (wr) begin
      if (size_ok(m)) begin
        m_mem[w] = ref_store(m_mem[w], wd, m, off);
        if (w == int'((LED_ADDR >> 2) % MEM_WORDS)) m_led = wd[7:0];
      end
      check_val("store_stall", clk_stall, 0);
      check_val("store_rd", read_data, m_rd);
      check_val("store_led", led, m_led);
    end else if (rd) begin
      if (m_line[l] == w) begin
        m_rd = ref_load(m_mem[w], m, off);
        check_val("hit_stall", clk_stall, 0);
        check_val("hit_rd", read_data, m_rd);
      end else begin
        for (int i = 0; i < LAT; i++) begin
          check_val("miss_stall", clk_stall, 1);
          addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom);
          memwrite = 1'($urandom_range(0, 1)); memread = 1'b1;
          @(posedge clk); #1;
        end
        memwrite = 1'b0; memread = 1'b0;
        m_line[l] = w;
        m_rd = ref_load(m_mem[w], m, off);
        check_val("miss_end_stall", clk_stall, 0);
        check_val("miss_rd", read_data, m_rd);
        check_val("miss_led", led, m_led);
      end
    end else begin
      check_val("idle_stall", clk_stall, 0);
      check_val("idle_rd", read_data, m_rd);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] sizes [8];
    sizes = '{3'd1, 3'd3, 3'd7, 3'd1, 3'd3, 3'd7, 3'd0, 3'd5};
    rst = 1'b1; addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0; sign_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rd", read_data, 0);
    check_val("rst_led", led, 0);
    check_val("rst_stall", clk_stall, 0);
    rst = 1'b0;

    for (int w = 0; w < 64; w++) op(1, 0, 32'(w * 4), $urandom, 4'b0111);
    op(1, 0, 32'h100, $urandom, 4'b0111);
    op(1, 0, 32'h400, $urandom, 4'b0111);

    op(1, 0, 32'h400, 32'hAAA, 4'b0001);
    op(0, 1, 32'h400, 0, 4'b1001);
    check_val("tp_byte_sx", read_data, 32'hFFFF_FFAA);
    op(0, 1, 32'h400, 0, 4'b0001);
    check_val("tp_byte_zx", read_data, 32'h0000_00AA);

    op(1, 0, 32'h100, 32'h2AAAA, 4'b0011);
    op(0, 1, 32'h100, 0, 4'b1011);
    check_val("tp_half_sx", read_data, 32'hFFFF_AAAA);
    op(0, 1, 32'h100, 0, 4'b0011);
    check_val("tp_half_zx", read_data, 32'h0000_AAAA);
    op(0, 1, 32'h102, 0, 4'b0011);

    op(1, 0, 32'h40, 32'hAAAA_AAAA, 4'b0111);
    op(0, 1, 32'h40, 0, 4'b0111);
    check_val("tp_word", read_data, 32'hAAAA_AAAA);
    op(1, 0, 32'h43, 32'h55, 4'b0001);
    op(0, 1, 32'h40, 0, 4'b0111);
    check_val("tp_merge", read_data, 32'h55AA_AAAA);
    op(0, 1, 32'h80, 0, 4'b0111);
    op(0, 1, 32'h40, 0, 4'b0111);

    op(1, 0, LED_ADDR, 32'h5A, 4'b0111);
    check_val("tp_led", led, 32'h5A);
    op(1, 1, 32'h44, 32'h1234_5678, 4'b0111);

    // abort a miss with reset in its second stall cycle
    @(negedge clk);
    addr = 32'h400; memread = 1'b1; sign_mask = 4'b0111;
    @(posedge clk); #1;
    memread = 1'b0;
    check_val("abort_stall_hi", clk_stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_val("abort_stall", clk_stall, 0);
    check_val("abort_rd", read_data, 0);
    check_val("abort_led", led, 0);
    op(0, 1, 32'h400, 0, 4'b0111);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  m;
      int          kind;
      a = 32'((($urandom_range(0, 3) * 16 + $urandom_range(0, 3)) * 4) + $urandom_range(0, 3))
          | (32'($urandom_range(0, 3)) << 12);
      m = {1'($urandom_range(0, 1)), sizes[$urandom_range(0, 7)]};
      kind = $urandom_range(0, 9);
      if (kind < 4)      op(1, 0, a, $urandom, m);
      else if (kind < 8) op(0, 1, a, 0, m);
      else if (kind < 9) op(1, 1, a, $urandom, m);
      else               op(0, 0, a, 0, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
